mem_arbiter: RTL
================

# mem_arbiter

Two-client burst memory arbiter that sits directly upstream of the DDR burst adapter. It multiplexes two burst-capable memory clients onto the adapter's single memory port. Lower index always has priority. Once a client's burst is accepted, the grant is locked to that client until the downstream port signals `burstDone`.

## Interface
- No parameters. Widths are fixed: address 32, data 64, mask 8, burst length 8.
- `clock  input  1`: sole clock; all state updates on its rising edge.
- `reset  input  1`: synchronous, active-high.
- `io_in_N_rd, io_in_N_wr  input  1` (N=0,1): client read/write request.
- `io_in_N_addr  input  32`; `io_in_N_mask  input  8`; `io_in_N_din  input  64`; `io_in_N_burstLength  input  8`.
- `io_in_N_dout  output  64`: read data, broadcast from `io_out_dout` to both clients.
- `io_in_N_wait_n  output  1`: accept/ready for client N; low unless N is selected.
- `io_in_N_valid  output  1`: read-data strobe; asserted only for the owning client.
- `io_in_N_burstDone  output  1`: end of burst; asserted only for the owning client.
- `io_out_rd, io_out_wr  output  1`; `io_out_addr  output  32`; `io_out_mask  output  8`; `io_out_din  output  64`; `io_out_burstLength  output  8`: muxed request to the DDR burst adapter.
- `io_out_dout  input  64`; `io_out_wait_n  input  1`; `io_out_valid  input  1`; `io_out_burstDone  input  1`: downstream response.

## Operation
- State machine:
  - `IDLE`, `BUSY`. One register `owner` (1 bit).
  - Reset gives `IDLE`, `owner=0`.
- Selection index `sel`:
  - In `IDLE`, `sel` = 0 if `io_in_0_rd|io_in_0_wr`, else 1 if `io_in_1_rd|io_in_1_wr`, else 0.
  - In `BUSY`, `sel = owner`.
- Output mux:
  - All `io_out_*` request fields are driven combinationally from client `sel`.
  - In `IDLE` with no request, `io_out_rd = io_out_wr = 0`.
  - In `BUSY`, `io_out_rd` is forced to 0. A locked read burst cannot issue a second read.
  - In `BUSY`, `io_out_wr` passes through, so write bursts continue.
- Response routing:
  - `io_in_sel_wait_n = io_out_wait_n`; the other client's `wait_n = 0`.
  - `io_in_owner_valid = io_out_valid` only in `BUSY`. A `valid` in `IDLE` is routed to the `sel` client.
  - `io_in_X_burstDone` is asserted only for X = `sel`.
  - `io_in_N_dout = io_out_dout` for both clients, always.
- Transitions (priority order):
  1. `io_out_burstDone` gives `IDLE`. This applies in both states, so a single-word burst accepted in `IDLE` with `burstDone` in the same cycle stays `IDLE`.
  2. In `IDLE`, `(io_out_rd|io_out_wr) & io_out_wait_n` gives `BUSY` and `owner <= sel`.
  3. Otherwise hold.
- Fairness: fixed priority. Client 1 can starve while client 0 requests continuously between bursts. This is accepted by design.
- Reset mid-burst: returns to `IDLE`, `owner=0`. No `burstDone` is generated. The downstream adapter is reset on the same reset.

## Timing
- Zero-cycle combinational path from the client request to `io_out_*`, and from `io_out_wait_n/valid/burstDone` to the client. No added latency.
- Grant takes effect in the acceptance cycle. The lock is registered and visible from the next cycle.
- A new arbitration is possible in the cycle after `burstDone`. Back-to-back bursts therefore have no idle bubble beyond the downstream one.
- Outputs in reset / `IDLE` with no requests:
  - `io_out_rd = io_out_wr = 0`; `io_out_addr/mask/din/burstLength` follow client 0.
  - All `io_in_N_valid = 0` and `io_in_N_burstDone = 0` unless downstream asserts them.
  - `io_in_0_wait_n = io_out_wait_n`; `io_in_1_wait_n = 0`.
- Client 1 sees `wait_n` high only when client 0 is not requesting in `IDLE`, or while client 1 owns the bus.

## Test plan
- Single read, client 1: `io_in_1_rd=1`, addr `0x100`, burstLength 4, `wait_n=1`. Expect `io_out_rd=1` and addr `0x100` in the same cycle, then `BUSY`. Four downstream `valid`s reach only `io_in_1_valid`. `io_in_1_burstDone` on the 4th; `IDLE` next cycle.
- Simultaneous requests: client 0 read (len 2) and client 1 write (len 2) in the same cycle. Client 0 is served first, and `io_in_1_wait_n` stays 0. After client 0's `burstDone`, client 1's write proceeds with 2 accepted words.
- Write burst with backpressure: client 0 write, len 4; `io_out_wait_n` low for 2 cycles mid-burst. `io_in_0_wait_n` mirrors it. `burstDone` arrives after the 4th accepted word, and `owner` holds throughout.
- Single-word burst: client 0 write, len 1, downstream `burstDone` in the acceptance cycle. The state remains `IDLE`, and client 1 can be granted in the next cycle.
- Read lock: while client 0 owns a read burst, client 0 reasserts `rd`. `io_out_rd` must stay 0 until after `burstDone`.
- Reset mid-burst: assert `reset` during client 1's burst. Next cycle: `IDLE`, `owner=0`, `io_out_rd=io_out_wr=0`, no spurious `burstDone`.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Burst memory port bundle shared by the clients and the downstream DDR adapter.
// master drives the request side, slave drives the response side.
interface mem_arbiter_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  mask;
    logic [63:0] din;
    logic [7:0]  burstLength;
    logic [63:0] dout;
    logic        wait_n;
    logic        valid;
    logic        burstDone;

    modport master (
        output rd, wr, addr, mask, din, burstLength,
        input  dout, wait_n, valid, burstDone
    );

    modport slave (
        input  rd, wr, addr, mask, din, burstLength,
        output dout, wait_n, valid, burstDone
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client fixed-priority burst arbiter; the grant locks to the accepted client
// until the downstream port reports burstDone.
module mem_arbiter (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  io_in_0,
    mem_arbiter_if.slave  io_in_1,
    mem_arbiter_if.master io_out
);
    typedef enum logic {IDLE, BUSY} state_e;

    state_e state_q;
    logic   owner_q;
    logic   req0;
    logic   req1;
    logic   sel;

    assign req0 = io_in_0.rd | io_in_0.wr;
    assign req1 = io_in_1.rd | io_in_1.wr;
    assign sel  = (state_q == BUSY) ? owner_q : (~req0 & req1);

    // Reads are blocked while locked: a read burst is issued once, then only data returns.
    always_comb begin
        io_out.rd          = sel ? io_in_1.rd          : io_in_0.rd;
        io_out.wr          = sel ? io_in_1.wr          : io_in_0.wr;
        io_out.addr        = sel ? io_in_1.addr        : io_in_0.addr;
        io_out.mask        = sel ? io_in_1.mask        : io_in_0.mask;
        io_out.din         = sel ? io_in_1.din         : io_in_0.din;
        io_out.burstLength = sel ? io_in_1.burstLength : io_in_0.burstLength;
        if (state_q == BUSY) begin
            io_out.rd = 1'b0;
        end
    end

    assign io_in_0.dout      = io_out.dout;
    assign io_in_1.dout      = io_out.dout;
    assign io_in_0.wait_n    = ~sel & io_out.wait_n;
    assign io_in_1.wait_n    =  sel & io_out.wait_n;
    assign io_in_0.valid     = ~sel & io_out.valid;
    assign io_in_1.valid     =  sel & io_out.valid;
    assign io_in_0.burstDone = ~sel & io_out.burstDone;
    assign io_in_1.burstDone =  sel & io_out.burstDone;

    // burstDone wins over acceptance so a one-word burst never enters BUSY.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
        end else if (io_out.burstDone) begin
            state_q <= IDLE;
        end else if (state_q == IDLE && (io_out.rd | io_out.wr) && io_out.wait_n) begin
            state_q <= BUSY;
            owner_q <= sel;
        end
    end
endmodule
